// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared defaults, stage-count helper and per-stage control record
package pipelined_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder_stage.sv
// rtl/chunk_adder_stage.sv - one registered CHUNK-bit adder slice with carry and valid pass-through
module chunk_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [CHUNK-1:0] sum_o
);

  stage_ctrl_t      ctrl_d, ctrl_q;
  logic [CHUNK-1:0] sum_d, sum_q;
  logic [CHUNK:0]   full_sum;

  always_comb begin
    ctrl_d   = '0;
    sum_d    = '0;
    full_sum = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
    ctrl_d.valid = valid_i;
    ctrl_d.carry = full_sum[CHUNK];
    sum_d        = full_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      sum_q  <= '0;
    end else if (en_i) begin
      ctrl_q <= ctrl_d;
      sum_q  <= sum_d;
    end
  end

  assign valid_o = ctrl_q.valid;
  assign carry_o = ctrl_q.carry;
  assign sum_o   = sum_q;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// rtl/pipelined_chunk_adder.sv - pipelined WIDTH-bit add/sub, one CHUNK slice per stage; ADDER_STATUS_FLAGS_EN adds zero/negative flags
module pipelined_chunk_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_num1,
  input  logic [WIDTH-1:0] input_num2,
  input  logic             carry_in,
  input  logic             sub_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_result,
  output logic             carry_out,
  output logic             overflow_out
`ifdef ADDER_STATUS_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             negative_flag
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] result;

  logic             valid_s [STAGES];
  logic             carry_s [STAGES];
  logic [CHUNK-1:0] sum_s   [STAGES];

  // Operands and already-finished low result bits that travel beside each slice.
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] lo_q [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || reset;
  assign b_eff    = sub_mode ? ~input_num2 : input_num2;
  assign cin_eff  = sub_mode ^ carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_sl, b_sl;
    logic             v_in, c_in;

    if (k == 0) begin : g_head
      assign a_sl = input_num1[CHUNK-1:0];
      assign b_sl = b_eff[CHUNK-1:0];
      assign v_in = in_valid;
      assign c_in = cin_eff;
    end else begin : g_body
      assign a_sl = a_q[k-1][k*CHUNK +: CHUNK];
      assign b_sl = b_q[k-1][k*CHUNK +: CHUNK];
      assign v_in = valid_s[k-1];
      assign c_in = carry_s[k-1];
    end

    chunk_adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en_i   (advance),
      .valid_i(v_in),
      .carry_i(c_in),
      .a_i    (a_sl),
      .b_i    (b_sl),
      .valid_o(valid_s[k]),
      .carry_o(carry_s[k]),
      .sum_o  (sum_s[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        lo_q[k] <= '0;
      end
    end else if (advance) begin
      a_q[0]  <= input_num1;
      b_q[0]  <= b_eff;
      lo_q[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k]  <= a_q[k-1];
        b_q[k]  <= b_q[k-1];
        lo_q[k] <= lo_q[k-1] | (WIDTH'(sum_s[k-1]) << ((k-1)*CHUNK));
      end
    end
  end

  // The last stage's registers are the output registers; they hold while stalled.
  assign result        = lo_q[STAGES-1] | (WIDTH'(sum_s[STAGES-1]) << ((STAGES-1)*CHUNK));
  assign out_valid     = valid_s[STAGES-1];
  assign output_result = result;
  assign carry_out     = carry_s[STAGES-1];
  assign overflow_out  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                         (result[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

`ifdef ADDER_STATUS_FLAGS_EN
  assign zero_flag     = out_valid && (result == '0);
  assign negative_flag = out_valid && result[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb/tb_pipelined_chunk_adder.sv - directed and randomized checks of pipelined_chunk_adder against a behavioural model
`timescale 1ns/1ps
module tb_pipelined_chunk_adder;

  localparam int STAGES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] input_num1 = '0;
  logic [31:0] input_num2 = '0;
  logic        carry_in = 1'b0;
  logic        sub_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] output_result;
  logic        carry_out;
  logic        overflow_out;
`ifdef ADDER_STATUS_FLAGS_EN
  logic        zero_flag;
  logic        negative_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  pipelined_chunk_adder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_num1   (input_num1),
    .input_num2   (input_num2),
    .carry_in     (carry_in),
    .sub_mode     (sub_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_result(output_result),
    .carry_out    (carry_out),
    .overflow_out (overflow_out)
`ifdef ADDER_STATUS_FLAGS_EN
    ,
    .zero_flag    (zero_flag),
    .negative_flag(negative_flag)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: sum/difference, unsigned carry (no-borrow) and signed range test.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic sub, output logic [31:0] r, output logic c,
                                output logic ov);
    longint ua, ub, sa, sb, tot, sv;
    logic [63:0] tv;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = $signed(a);
    sb = $signed(b);
    if (!sub) begin
      tot = ua + ub + longint'(cin);
      c   = (tot >= 64'h1_0000_0000);
      sv  = sa + sb + longint'(cin);
    end else begin
      tot = ua - ub - longint'(cin);
      c   = (ua >= ub + longint'(cin));
      sv  = sa - sb - longint'(cin);
    end
    tv = tot;
    r  = tv[31:0];
    ov = (sv != longint'($signed(r)));
  endfunction

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        ov;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          stalls = 0;
  bit          presented = 0;
  bit          held_v = 0;
  logic [31:0] held_r;
  logic        held_c, held_ov;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      presented = 0;
      held_v    = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", output_result, held_r);
        chk("hold_carry", carry_out, held_c);
        chk("hold_ovf", overflow_out, held_ov);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("result", output_result, q[0].r);
          chk("carry_out", carry_out, q[0].c);
          chk("overflow", overflow_out, q[0].ov);
`ifdef ADDER_STATUS_FLAGS_EN
          chk("zero_flag", zero_flag, q[0].r == 32'h0);
          chk("negative_flag", negative_flag, q[0].r[31]);
`endif
          if (!presented)
            chk("latency", 64'(cyc - q[0].acc_cyc - STAGES), 64'(stalls - q[0].acc_stall));
          presented = 1;
          if (out_ready) begin
            void'(q.pop_front());
            presented = 0;
            n_out++;
          end
        end
      end
      held_v  = out_valid && !out_ready;
      held_r  = output_result;
      held_c  = carry_out;
      held_ov = overflow_out;
      if (in_valid && in_ready) begin
        model(input_num1, input_num2, carry_in, sub_mode, e.r, e.c, e.ov);
        e.acc_cyc   = cyc;
        e.acc_stall = stalls;
        q.push_back(e);
        n_acc++;
      end
      if (out_valid && !out_ready) stalls++;
    end
    cyc++;
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [4];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000;
    if ($urandom_range(7) == 0) return edges[$urandom_range(3)];
    return $urandom();
  endfunction

  task automatic drive_random(input logic v);
    in_valid   = v;
    input_num1 = pick_operand();
    input_num2 = pick_operand();
    carry_in   = 1'($urandom_range(1));
    sub_mode   = 1'($urandom_range(1));
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] er,
                          input logic ec, input logic eo);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    @(posedge clk); #1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    input_num1 = a;
    input_num2 = b;
    carry_in   = cin;
    sub_mode   = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        lat  = i + 1;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 1'b0, 1'b1);
    end else begin
      chk({nm, "_latency"}, 64'(lat), 64'(STAGES));
      chk({nm, "_result"}, output_result, er);
      chk({nm, "_carry"}, carry_out, ec);
      chk({nm, "_ovf"}, overflow_out, eo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int out0, acc0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", in_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", output_result, 32'h0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_ovf", overflow_out, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    directed("add_f_1", 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_borrow", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed("add_cin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
    drain();

    out0 = n_out;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive_random(1'b1);
    end
    drain();
    chk("stream_count", 64'(n_out - out0), 64'd20);

    out0 = n_out;
    acc0 = n_acc;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive_random(1'b1);
      if (i >= 9) begin
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
      end
    end
    drain();
    chk("bp_accepted", 64'(n_acc - acc0), 64'd8);
    chk("bp_delivered", 64'(n_out - out0), 64'd8);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      drive_random(1'($urandom_range(9) < 7));
      out_ready = 1'($urandom_range(9) < 7);
    end
    drain();
    chk("random_all_delivered", 64'(n_out), 64'(n_acc));

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_random(1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", output_result, 32'h0);
    chk("midrst_carry", carry_out, 1'b0);
    chk("midrst_ovf", overflow_out, 1'b0);
    directed("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_reset_alone", out_valid, 1'b0);

    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
